gui_draw_scheduler: RTL and testbench
=====================================

// Module: gui_draw_scheduler
// PURPOSE
//  Shares the single VGA pixel-write port between four sprite requesters: the lampboard
//  (index 0) and rotor wheels 1-3 (indices 1-3).
//  Holds sticky per-sprite dirty flags. On each frame tick it runs one redraw sweep.
//  Each dirty sprite is raster-scanned in turn, one pixel per clk, with plot asserted.
//  Sits between the enigma state logic and the gui datapath; the datapath turns sel+offsets into x/y/colour.
// PARAMETERS
//  LAMP_W   7  lampboard sprite width  (pixels)
//  LAMP_H   7  lampboard sprite height (pixels)
//  GLYPH_W  5  wheel glyph width
//  GLYPH_H  5  wheel glyph height
// PORTS
//  clk         in   1  system clock (CLOCK_50 domain)
//  resetn      in   1  asynchronous, active-low reset
//  frame_tick  in   1  one-cycle pulse per video frame (60 Hz)
//  req         in   4  one-cycle redraw request per sprite; bit0 lamp, bit1..3 wheel1..3
//  draw_sel    out  2  sprite being drawn: 0 lamp, 1..3 wheel
//  off_x       out  3  column within sprite
//  off_y       out  3  row within sprite
//  pix_idx     out  6  row*W+col, the bitmap index for the datapath
//  plot        out  1  pixel write enable
//  busy        out  1  sweep in progress (state != IDLE)
//  sweep_done  out  1  one-cycle pulse on the final pixel of a sweep
// BEHAVIOUR
//  - Reset values:
//    - All outputs 0; state IDLE; tick_pend 0; snapshot 0.
//    - dirty = 4'b1111, so the first frame paints everything.
//    - Reset is asynchronous: plot drops immediately mid-scan; no partial sprite resumes.
//  - All outputs are registered.
//  - tick_pend: set by frame_tick in any state; cleared when IDLE evaluates it.
//  - dirty: dirty[i] is set by req[i] in any state.
//  - FSM IDLE -> ARB -> SCAN {-> ARB -> SCAN}* -> IDLE.
//  - IDLE:
//    - If tick_pend and dirty!=0: snapshot<=dirty, dirty<=req (clear served bits, keep same-cycle reqs), go to ARB.
//    - If tick_pend and dirty==0: clear tick_pend, stay IDLE.
//  - ARB (plot=0, one cycle):
//    - Pick the lowest set snapshot bit (lamp highest priority).
//    - draw_sel<=bit, clear that snapshot bit, col=row=0, go to SCAN.
//  - SCAN:
//    - Each cycle: plot=1, off_x=col, off_y=row, pix_idx=row*W+col.
//    - W,H = LAMP_W/H when sel=0, else GLYPH_W/H.
//    - col wraps at W-1 and increments row.
//    - On col=W-1 and row=H-1: if snapshot!=0 go to ARB; else pulse sweep_done and go to IDLE.
//  - Latency: frame_tick sampled at edge k -> first plot=1 after edge k+2 (IDLE, ARB).
//  - Full sweep (all dirty): 4 ARB + 49 + 3x25 = 128 busy cycles, of which 124 have plot=1.
//  - Mid-sweep events:
//    - frame_tick during a sweep: latched in tick_pend; the next sweep starts right after IDLE if dirty.
//    - req for the sprite currently being scanned: re-dirties it; redrawn next sweep, not this one.
//    - req for a sprite already in the snapshot: drawn this sweep AND flagged for the next sweep.
//  - Widths: pix_idx max 48 fits 6 bits; col/row 3 bits; no arithmetic overflow.
// STRUCTURE
//  - Shared package gui_pkg:
//    - SEL_LAMP=0, SEL_W1..SEL_W3
//    - sprite size constants
//    - state encoding IDLE/ARB/SCAN
//  - One sub-module gui_raster_counter (col/row/idx counter with runtime W,H inputs, last flag).
//  - Arbitration and the FSM stay in this module.
// TESTING
//  - Reset release, then frame_tick:
//    - Sweep draws sel 0,1,2,3 in order.
//    - 124 plot cycles; busy high for exactly 128 cycles; one sweep_done.
//  - req=4'b0100 only, then tick:
//    - sel=2 for 25 plot cycles.
//    - off_x/off_y step (0,0)..(4,4); pix_idx 0..24.
//  - frame_tick with dirty==0 -> no plot, busy stays 0, tick_pend cleared.
//  - During the sel=1 scan, pulse req[1] and frame_tick:
//    - The current sweep completes.
//    - A second sweep starts immediately and draws only sel=1.
//  - Assert resetn=0 at pixel 20 of the lamp scan:
//    - plot/busy drop asynchronously.
//    - After release and tick, a full 4-sprite sweep runs.
//  - req[0] and frame_tick in the same cycle while IDLE with dirty==0:
//    - Lamp is drawn; plot first high after edge k+3 (the first tick is missed because dirty==0 when sampled).

Source files
------------

// File: rtl/gui_pkg.sv
// Shared definitions for the GUI draw scheduler: sprite selects, sprite sizes, FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gui_pkg;

  // Sprite selects as driven on draw_sel.
  localparam logic [1:0] SEL_LAMP = 2'd0;
  localparam logic [1:0] SEL_W1   = 2'd1;
  localparam logic [1:0] SEL_W2   = 2'd2;
  localparam logic [1:0] SEL_W3   = 2'd3;

  // Default sprite geometry in pixels.
  localparam int unsigned LAMP_W_DEF  = 7;
  localparam int unsigned LAMP_H_DEF  = 7;
  localparam int unsigned GLYPH_W_DEF = 5;
  localparam int unsigned GLYPH_H_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_SCAN = 2'd2
  } state_e;

  // Fixed priority: the lampboard (bit 0) wins, then wheels 1..3.
  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    if (v[0])      return SEL_LAMP;
    else if (v[1]) return SEL_W1;
    else if (v[2]) return SEL_W2;
    else           return SEL_W3;
  endfunction

endpackage

// File: rtl/gui_raster_counter.sv
// Raster counter: walks col/row across a W x H sprite and keeps the linear bitmap index.
// Latency: position updates one clk after en_i/clr_i; last_o is combinational from the registers.
// Backpressure: none; advances exactly when en_i is high, clr_i has priority.
//
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   clr_i         restart at (0,0)
//   en_i          advance one pixel
//   w_i, h_i      sprite width/height, may change between sprites
//   col_o, row_o  current pixel position
//   idx_o         row*W+col of the current pixel
//   last_o        current pixel is the bottom-right one
module gui_raster_counter (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [2:0] w_i,
  input  logic [2:0] h_i,
  output logic [2:0] col_o,
  output logic [2:0] row_o,
  output logic [5:0] idx_o,
  output logic       last_o
);

  logic [2:0] col_q, col_d;
  logic [2:0] row_q, row_d;
  logic [5:0] idx_q, idx_d;
  logic       col_end;
  logic       row_end;

  assign col_end = (col_q == (w_i - 3'd1));
  assign row_end = (row_q == (h_i - 3'd1));
  assign last_o  = col_end && row_end;

  // The scan is strictly row-major, so row*W+col is just a running pixel
  // count; no multiplier needed. It returns to 0 together with col/row.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    idx_d = idx_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
      idx_d = '0;
    end else if (en_i) begin
      if (col_end) begin
        col_d = '0;
        if (row_end) begin
          row_d = '0;
          idx_d = '0;
        end else begin
          row_d = row_q + 3'd1;
          idx_d = idx_q + 6'd1;
        end
      end else begin
        col_d = col_q + 3'd1;
        idx_d = idx_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_q <= '0;
      row_q <= '0;
      idx_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      idx_q <= idx_d;
    end
  end

  assign col_o = col_q;
  assign row_o = row_q;
  assign idx_o = idx_q;

endmodule

// File: rtl/gui_draw_scheduler.sv
// Shares the VGA pixel-write port between the lampboard and three rotor-wheel sprites, one redraw sweep per frame tick.
// Latency: frame_tick at edge k gives the first plot after edge k+2; one idle pixel slot (ARB) between sprites.
// Backpressure: none; requests are sticky dirty bits, a tick arriving mid-sweep is held until the sweep ends.
//
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   frame_tick       one-cycle pulse per video frame
//   req[3:0]         one-cycle redraw request; bit0 lamp, bits1..3 wheel1..3
//   draw_sel[1:0]    sprite being drawn
//   off_x, off_y     column/row within the sprite
//   pix_idx[5:0]     row*W+col bitmap index
//   plot             pixel write enable
//   busy             sweep in progress
//   sweep_done       pulse on the final pixel of a sweep
module gui_draw_scheduler
  import gui_pkg::*;
#(
  parameter int unsigned LAMP_W  = LAMP_W_DEF,
  parameter int unsigned LAMP_H  = LAMP_H_DEF,
  parameter int unsigned GLYPH_W = GLYPH_W_DEF,
  parameter int unsigned GLYPH_H = GLYPH_H_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic [3:0] req,
  output logic [1:0] draw_sel,
  output logic [2:0] off_x,
  output logic [2:0] off_y,
  output logic [5:0] pix_idx,
  output logic       plot,
  output logic       busy,
  output logic       sweep_done
);

  state_e     state_q, state_d;
  logic       tick_pend_q, tick_pend_d;
  logic [3:0] dirty_q, dirty_d;
  logic [3:0] snap_q, snap_d;
  logic [1:0] sel_q, sel_d;
  logic       tick_now;

  logic       cnt_clr;
  logic       cnt_en;
  logic [2:0] cnt_w;
  logic [2:0] cnt_h;
  logic [2:0] col;
  logic [2:0] row;
  logic [5:0] idx;
  logic       last;

  // Output registers: each reflects the state/position of the previous cycle.
  logic [1:0] draw_sel_q;
  logic [2:0] off_x_q;
  logic [2:0] off_y_q;
  logic [5:0] pix_idx_q;
  logic       plot_q;
  logic       busy_q;
  logic       sweep_done_q;

  assign cnt_w    = (sel_q == SEL_LAMP) ? 3'(LAMP_W) : 3'(GLYPH_W);
  assign cnt_h    = (sel_q == SEL_LAMP) ? 3'(LAMP_H) : 3'(GLYPH_H);
  assign tick_now = tick_pend_q | frame_tick;

  gui_raster_counter u_raster (
    .clk    (clk),
    .resetn (resetn),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .w_i    (cnt_w),
    .h_i    (cnt_h),
    .col_o  (col),
    .row_o  (row),
    .idx_o  (idx),
    .last_o (last)
  );

  always_comb begin
    state_d     = state_q;
    tick_pend_d = tick_pend_q | frame_tick;
    dirty_d     = dirty_q | req;
    snap_d      = snap_q;
    sel_d       = sel_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick_now) begin
          if (dirty_q != '0) begin
            // Hand the dirty set to this sweep; requests landing this
            // same cycle stay dirty for the next sweep.
            snap_d      = dirty_q;
            dirty_d     = req;
            tick_pend_d = 1'b0;
            state_d     = ST_ARB;
          end else begin
            // Nothing to draw: drop the pending tick, but a tick arriving
            // right now is held one more cycle so a request that came with
            // it is still served this frame.
            tick_pend_d = frame_tick;
          end
        end
      end
      ST_ARB: begin
        sel_d   = lowest_set(snap_q);
        snap_d  = snap_q & ~(4'b0001 << sel_d);
        cnt_clr = 1'b1;
        state_d = ST_SCAN;
      end
      ST_SCAN: begin
        cnt_en = 1'b1;
        if (last) begin
          state_d = (snap_q != '0) ? ST_ARB : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      tick_pend_q  <= 1'b0;
      dirty_q      <= 4'b1111;  // first frame after reset paints everything
      snap_q       <= '0;
      sel_q        <= SEL_LAMP;
      draw_sel_q   <= '0;
      off_x_q      <= '0;
      off_y_q      <= '0;
      pix_idx_q    <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_pend_q  <= tick_pend_d;
      dirty_q      <= dirty_d;
      snap_q       <= snap_d;
      sel_q        <= sel_d;
      draw_sel_q   <= sel_q;
      off_x_q      <= (state_q == ST_SCAN) ? col : 3'd0;
      off_y_q      <= (state_q == ST_SCAN) ? row : 3'd0;
      pix_idx_q    <= (state_q == ST_SCAN) ? idx : 6'd0;
      plot_q       <= (state_q == ST_SCAN);
      busy_q       <= (state_q != ST_IDLE);
      sweep_done_q <= (state_q == ST_SCAN) && last && (snap_q == '0);
    end
  end

  assign draw_sel   = draw_sel_q;
  assign off_x      = off_x_q;
  assign off_y      = off_y_q;
  assign pix_idx    = pix_idx_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_gui_draw_scheduler.sv
module tb_gui_draw_scheduler;

  logic       clk = 1'b0;
  logic       resetn;
  logic       frame_tick;
  logic [3:0] req;
  logic [1:0] draw_sel;
  logic [2:0] off_x;
  logic [2:0] off_y;
  logic [5:0] pix_idx;
  logic       plot;
  logic       busy;
  logic       sweep_done;

  always #5 clk = ~clk;

  gui_draw_scheduler dut (
    .clk        (clk),
    .resetn     (resetn),
    .frame_tick (frame_tick),
    .req        (req),
    .draw_sel   (draw_sel),
    .off_x      (off_x),
    .off_y      (off_y),
    .pix_idx    (pix_idx),
    .plot       (plot),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  localparam int WIN  = 200;
  localparam int NVEC = 11;

  // One record per scenario: request pulse, tick, optional mid-sweep
  // injection, and the expected sprite order / counts over the window.
  // seq packs sprite selects 2 bits each, first sprite in bits [1:0];
  // done_mask bit j means a sweep ends on the last pixel of sprite j.
  typedef struct {
    logic [3:0] rq;
    bit         tick;
    bit         with_tick;
    int         inj_n;
    logic [3:0] inj_rq;
    bit         inj_tick;
    int         nseq;
    logic [9:0] seq;
    logic [4:0] done_mask;
    int         exp_plots;
    int         exp_busy;
    int         exp_done;
    int         exp_first;
  } vec_t;

  vec_t vecs [NVEC];
  int   n_vec = 0;
  int   n_err = 0;
  int   cur   = -1;

  function automatic vec_t mk(input logic [3:0] rq, input bit tk, input bit wt,
                              input int inj_n, input logic [3:0] inj_rq, input bit inj_tk,
                              input int nseq, input logic [9:0] seq, input logic [4:0] dm,
                              input int pl, input int bs, input int dn, input int fs);
    vec_t v;
    v.rq = rq; v.tick = tk; v.with_tick = wt;
    v.inj_n = inj_n; v.inj_rq = inj_rq; v.inj_tick = inj_tk;
    v.nseq = nseq; v.seq = seq; v.done_mask = dm;
    v.exp_plots = pl; v.exp_busy = bs; v.exp_done = dn; v.exp_first = fs;
    return v;
  endfunction

  function automatic void chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL v%0d %s: got %0d, expected %0d", cur, name, act, exp);
    end
  endfunction

  task automatic run_vec(input vec_t v);
    int plots = 0;
    int busys = 0;
    int dones = 0;
    int first = -1;
    int j = 0;
    int col = 0;
    int row = 0;
    int w;
    int h;
    logic [1:0] es;
    @(negedge clk);
    req = v.rq;
    if (!v.with_tick) begin
      @(negedge clk);
      req = '0;
    end
    frame_tick = v.tick;
    @(negedge clk);
    req = '0;
    frame_tick = 1'b0;
    // n counts negedges after the edge that sampled the tick.
    for (int n = 0; n < WIN; n++) begin
      if (n == v.inj_n) begin
        req = v.inj_rq;
        frame_tick = v.inj_tick;
      end else begin
        req = '0;
        frame_tick = 1'b0;
      end
      if (busy) busys++;
      if (sweep_done) dones++;
      if (plot) begin
        if (first < 0) first = n;
        plots++;
        if (j < v.nseq) begin
          es = v.seq[2*j +: 2];
          w = (es == 2'd0) ? 7 : 5;
          h = w;
          chk("draw_sel", int'(draw_sel), int'(es));
          chk("off_x", int'(off_x), col);
          chk("off_y", int'(off_y), row);
          chk("pix_idx", int'(pix_idx), row * w + col);
          chk("sweep_done", int'(sweep_done),
              (col == w - 1 && row == h - 1 && v.done_mask[j]) ? 1 : 0);
          if (col == w - 1) begin
            col = 0;
            if (row == h - 1) begin
              row = 0;
              j++;
            end else begin
              row++;
            end
          end else begin
            col++;
          end
        end
      end
      @(negedge clk);
    end
    chk("plot cycles", plots, v.exp_plots);
    chk("busy cycles", busys, v.exp_busy);
    chk("sweep_done pulses", dones, v.exp_done);
    chk("first plot cycle", first, v.exp_first);
    chk("sprites drawn", j, v.nseq);
  endtask

  initial begin
    resetn = 1'b0;
    frame_tick = 1'b0;
    req = '0;

    //          rq       tk wt inj  injrq    it nseq seq                                   done      plots busy done first
    vecs[0]  = mk(4'b0000, 1, 0, -1, 4'b0000, 0, 4, {2'd0,2'd3,2'd2,2'd1,2'd0}, 5'b01000, 124, 128, 1,  2);
    vecs[1]  = mk(4'b0100, 1, 0, -1, 4'b0000, 0, 1, {2'd0,2'd0,2'd0,2'd0,2'd2}, 5'b00001,  25,  26, 1,  2);
    vecs[2]  = mk(4'b0000, 1, 0, -1, 4'b0000, 0, 0, 10'd0,                      5'b00000,   0,   0, 0, -1);
    vecs[3]  = mk(4'b0001, 0, 0, -1, 4'b0000, 0, 0, 10'd0,                      5'b00000,   0,   0, 0, -1);
    vecs[4]  = mk(4'b0000, 1, 0, -1, 4'b0000, 0, 1, {2'd0,2'd0,2'd0,2'd0,2'd0}, 5'b00001,  49,  50, 1,  2);
    vecs[5]  = mk(4'b1001, 1, 0, -1, 4'b0000, 0, 2, {2'd0,2'd0,2'd0,2'd3,2'd0}, 5'b00010,  74,  76, 1,  2);
    vecs[6]  = mk(4'b1111, 1, 0, 60, 4'b0010, 1, 5, {2'd1,2'd3,2'd2,2'd1,2'd0}, 5'b11000, 149, 154, 2,  2);
    vecs[7]  = mk(4'b1111, 1, 0, 60, 4'b1000, 0, 4, {2'd0,2'd3,2'd2,2'd1,2'd0}, 5'b01000, 124, 128, 1,  2);
    vecs[8]  = mk(4'b0000, 1, 0, -1, 4'b0000, 0, 1, {2'd0,2'd0,2'd0,2'd0,2'd3}, 5'b00001,  25,  26, 1,  2);
    vecs[9]  = mk(4'b1110, 1, 0, -1, 4'b0000, 0, 3, {2'd0,2'd0,2'd3,2'd2,2'd1}, 5'b00100,  75,  78, 1,  2);
    vecs[10] = mk(4'b0001, 1, 1, -1, 4'b0000, 0, 1, {2'd0,2'd0,2'd0,2'd0,2'd0}, 5'b00001,  49,  50, 1,  3);

    repeat (3) @(negedge clk);
    chk("reset plot", int'(plot), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset sweep_done", int'(sweep_done), 0);
    chk("reset draw_sel", int'(draw_sel), 0);
    chk("reset off_x", int'(off_x), 0);
    chk("reset off_y", int'(off_y), 0);
    chk("reset pix_idx", int'(pix_idx), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      cur = i;
      run_vec(vecs[i]);
    end

    // Asynchronous reset at lamp pixel 20 of a full sweep.
    cur = 11;
    @(negedge clk);
    req = 4'b1111;
    @(negedge clk);
    req = '0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (22) @(negedge clk);
    chk("pre-reset plot", int'(plot), 1);
    chk("pre-reset draw_sel", int'(draw_sel), 0);
    chk("pre-reset pix_idx", int'(pix_idx), 20);
    #2 resetn = 1'b0;
    #1;
    chk("async reset plot", int'(plot), 0);
    chk("async reset busy", int'(busy), 0);
    chk("async reset pix_idx", int'(pix_idx), 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    cur = 12;
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
